// File: rtl/fusion_pkg.sv
// Shared types and widths for the fusion accumulator slice.
// Optional feature macro used by this slice: SATURATE_EN (per-lane clamping).
package fusion_pkg;

  localparam int COL_W         = 13;
  localparam int IN_W          = 2 * COL_W;
  localparam int ACC_W_DEFAULT = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } fusion_acc_state_t;

  typedef struct packed {
    logic split;
    logic sign;
  } fusion_mode_t;

endpackage

// File: rtl/fusion_acc_adder.sv
// Combinational extend-and-add for full and split modes; lanes never carry into each other.
// With SATURATE_EN defined each lane clamps and stays clamped while its sticky flag is set.
module fusion_acc_adder
  import fusion_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  in_sum,
  input  fusion_mode_t     mode,
`ifdef SATURATE_EN
  input  logic [1:0]       sat_in,
  output logic [1:0]       sat_out,
`endif
  output logic [ACC_W-1:0] sum
);

  localparam int LANE_W = ACC_W / 2;

  logic [ACC_W-1:0]  op_full;
  logic [LANE_W-1:0] op_l0;
  logic [LANE_W-1:0] op_l1;

  always_comb begin
    op_full = {{(ACC_W-IN_W){mode.sign & in_sum[IN_W-1]}}, in_sum};
    op_l0   = {{(LANE_W-COL_W){mode.sign & in_sum[COL_W-1]}}, in_sum[COL_W-1:0]};
    op_l1   = {{(LANE_W-COL_W){mode.sign & in_sum[IN_W-1]}}, in_sum[IN_W-1:COL_W]};
  end

`ifdef SATURATE_EN
  // Returns {clamped, value}; signed overflow only when both operands share a sign.
  function automatic logic [ACC_W:0] clamp_full(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b,
                                                input logic sgn);
    logic [ACC_W:0] raw;
    logic [ACC_W:0] res;
    raw = {1'b0, a} + {1'b0, b};
    res = {1'b0, raw[ACC_W-1:0]};
    if (!sgn) begin
      if (raw[ACC_W]) res = {1'b1, {ACC_W{1'b1}}};
    end else if ((a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1])) begin
      res = {1'b1, a[ACC_W-1], {(ACC_W-1){~a[ACC_W-1]}}};
    end
    return res;
  endfunction

  function automatic logic [LANE_W:0] clamp_lane(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b,
                                                 input logic sgn);
    logic [LANE_W:0] raw;
    logic [LANE_W:0] res;
    raw = {1'b0, a} + {1'b0, b};
    res = {1'b0, raw[LANE_W-1:0]};
    if (!sgn) begin
      if (raw[LANE_W]) res = {1'b1, {LANE_W{1'b1}}};
    end else if ((a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1])) begin
      res = {1'b1, a[LANE_W-1], {(LANE_W-1){~a[LANE_W-1]}}};
    end
    return res;
  endfunction

  logic [ACC_W:0]  res_full;
  logic [LANE_W:0] res_l0;
  logic [LANE_W:0] res_l1;

  always_comb begin
    res_full = clamp_full(acc, op_full, mode.sign);
    res_l0   = clamp_lane(acc[LANE_W-1:0], op_l0, mode.sign);
    res_l1   = clamp_lane(acc[ACC_W-1:LANE_W], op_l1, mode.sign);
    sum      = '0;
    sat_out  = '0;
    if (!mode.split) begin
      if (sat_in[0]) begin
        sum     = acc;
        sat_out = 2'b01;
      end else begin
        sum     = res_full[ACC_W-1:0];
        sat_out = {1'b0, res_full[ACC_W]};
      end
    end else begin
      sum[LANE_W-1:0]     = sat_in[0] ? acc[LANE_W-1:0] : res_l0[LANE_W-1:0];
      sum[ACC_W-1:LANE_W] = sat_in[1] ? acc[ACC_W-1:LANE_W] : res_l1[LANE_W-1:0];
      sat_out[0]          = sat_in[0] | res_l0[LANE_W];
      sat_out[1]          = sat_in[1] | res_l1[LANE_W];
    end
  end
`else
  logic [LANE_W-1:0] wrap_l0;
  logic [LANE_W-1:0] wrap_l1;

  always_comb begin
    wrap_l0 = acc[LANE_W-1:0] + op_l0;
    wrap_l1 = acc[ACC_W-1:LANE_W] + op_l1;
    sum     = mode.split ? {wrap_l1, wrap_l0} : (acc + op_full);
  end
`endif

endmodule

// File: rtl/fusion_accumulator.sv
// Accumulates in_last-terminated groups of fusion sums and holds each result on a valid/ready port.
// Build option: define SATURATE_EN for clamping adds instead of modulo wrap.
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_split,
  input  logic             in_sign,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_split,
  output logic             mode_err
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds its payload stable until then, and ready never depends on valid.

  fusion_acc_state_t state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic              out_split_q, out_split_d;
  logic              out_valid_q, out_valid_d;
  logic              mode_err_q, mode_err_d;
  logic              first_q, first_d;
  fusion_mode_t      mode_q, mode_d;

  fusion_mode_t      in_mode;
  fusion_mode_t      eff_mode;
  logic              beat;
  logic [ACC_W-1:0]  sum;

`ifdef SATURATE_EN
  logic [1:0]        sat_q, sat_d;
  logic [1:0]        sat_out;
`endif

  assign in_mode   = '{split: in_split, sign: in_sign};
  assign eff_mode  = first_q ? in_mode : mode_q;
  assign in_ready  = (state_q == ACCUM);
  assign beat      = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_split = out_split_q;
  assign mode_err  = mode_err_q;

  fusion_acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .acc     (acc_q),
    .in_sum  (in_sum),
    .mode    (eff_mode),
`ifdef SATURATE_EN
    .sat_in  (sat_q),
    .sat_out (sat_out),
`endif
    .sum     (sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_acc_d   = out_acc_q;
    out_split_d = out_split_q;
    out_valid_d = out_valid_q;
    mode_err_d  = 1'b0;
    first_d     = first_q;
    mode_d      = mode_q;
`ifdef SATURATE_EN
    sat_d       = sat_q;
`endif
    unique case (state_q)
      ACCUM: begin
        if (beat) begin
          // Later beats keep the group's latched mode; a differing beat is only flagged.
          if (first_q) mode_d = in_mode;
          else         mode_err_d = (in_mode != mode_q);
          if (in_last) begin
            out_acc_d   = sum;
            out_split_d = eff_mode.split;
            out_valid_d = 1'b1;
            acc_d       = '0;
            first_d     = 1'b1;
`ifdef SATURATE_EN
            sat_d       = '0;
`endif
            state_d     = HOLD;
          end else begin
            acc_d   = sum;
            first_d = 1'b0;
`ifdef SATURATE_EN
            sat_d   = sat_out;
`endif
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      out_acc_q   <= '0;
      out_split_q <= 1'b0;
      out_valid_q <= 1'b0;
      mode_err_q  <= 1'b0;
      first_q     <= 1'b1;
      mode_q      <= '0;
`ifdef SATURATE_EN
      sat_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_acc_q   <= out_acc_d;
      out_split_q <= out_split_d;
      out_valid_q <= out_valid_d;
      mode_err_q  <= mode_err_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
`ifdef SATURATE_EN
      sat_q       <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_fusion_accumulator.sv
// Bench for fusion_accumulator: table-driven groups, scoreboard on the output port,
// hand sequences for backpressure, reset, mode error and a 28-bit wrap/saturate instance.
module tb_fusion_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_split, in_sign, in_last;
  logic [25:0] in_sum;
  logic        out_valid, out_ready, out_split, mode_err;
  logic [31:0] out_acc;

  logic        in_valid28, in_ready28, in_last28;
  logic [25:0] in_sum28;
  logic        out_valid28, out_split28, mode_err28;
  logic [27:0] out_acc28;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  fusion_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_split(in_split), .in_sign(in_sign), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_split(out_split), .mode_err(mode_err)
  );

  fusion_accumulator #(.ACC_W(28)) u_dut28 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid28), .in_ready(in_ready28),
    .in_sum(in_sum28), .in_split(1'b0), .in_sign(1'b0), .in_last(in_last28),
    .out_valid(out_valid28), .out_ready(1'b1), .out_acc(out_acc28),
    .out_split(out_split28), .mode_err(mode_err28)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare each result as it is handed to the consumer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'(0));
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_acc", out_acc, e[31:0]);
        check("out_split", 32'(out_split), 32'(e[32]));
      end
    end
  end

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [25:0] s,
                                            input logic sp, input logic sg);
    logic [15:0] l0, l1;
    if (!sp) return a + {{6{sg & s[25]}}, s};
    l0 = a[15:0] + {{3{sg & s[12]}}, s[12:0]};
    l1 = a[31:16] + {{3{sg & s[25]}}, s[25:13]};
    return {l1, l0};
  endfunction

  // driver: called at a negedge, returns at the negedge after the beat is accepted
  task automatic drive_beat(input logic [25:0] s, input logic sp, input logic sg, input logic lst);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 20) check("in_ready_timeout", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_sum   = s;
    in_split = sp;
    in_sign  = sg;
    in_last  = lst;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  typedef struct packed {
    logic [1:0]  n;
    logic [25:0] s0;
    logic [25:0] s1;
    logic [25:0] s2;
    logic        split;
    logic        sign;
    logic [31:0] exp_acc;
    logic        exp_split;
  } vec_t;

  vec_t vecs[7];

  task automatic run_group(input vec_t v);
    logic [25:0] s;
    exp_q.push_back({v.exp_split, v.exp_acc});
    for (int b = 0; b < int'(v.n); b++) begin
      s = (b == 0) ? v.s0 : ((b == 1) ? v.s1 : v.s2);
      drive_beat(s, v.split, v.sign, b == int'(v.n) - 1);
    end
    check("latency_out_valid", 32'(out_valid), 32'(1));
  endtask

  initial begin
    logic [31:0] acc_m;
    logic [25:0] rs;
    logic        rsp, rsg;
    logic [27:0] exp28;
    int          n;

    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_split = 1'b0; in_sign = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    in_valid28 = 1'b0; in_sum28 = '0; in_last28 = 1'b0;

    vecs[0] = '{n: 2'd3, s0: 26'd100, s1: 26'd200, s2: 26'd300, split: 1'b0, sign: 1'b0,
                exp_acc: 32'd600, exp_split: 1'b0};
    vecs[1] = '{n: 2'd2, s0: {13'h1FFF, 13'd5}, s1: {13'h1FFF, 13'd5}, s2: 26'd0,
                split: 1'b1, sign: 1'b1, exp_acc: 32'hFFFE_000A, exp_split: 1'b1};
    vecs[2] = '{n: 2'd2, s0: 26'h3FFFFFF, s1: 26'd5, s2: 26'd0, split: 1'b0, sign: 1'b1,
                exp_acc: 32'd4, exp_split: 1'b0};
    vecs[3] = '{n: 2'd3, s0: {13'h1FFF, 13'h1FFF}, s1: {13'h1FFF, 13'h1FFF},
                s2: {13'h1FFF, 13'h1FFF}, split: 1'b1, sign: 1'b0,
                exp_acc: 32'h5FFD_5FFD, exp_split: 1'b1};
    vecs[4] = '{n: 2'd1, s0: 26'h3FFFFFF, s1: 26'd0, s2: 26'd0, split: 1'b0, sign: 1'b0,
                exp_acc: 32'h03FF_FFFF, exp_split: 1'b0};
    vecs[5] = '{n: 2'd2, s0: 26'h3FFFF9C, s1: 26'd30, s2: 26'd0, split: 1'b0, sign: 1'b1,
                exp_acc: 32'hFFFF_FFBA, exp_split: 1'b0};
    vecs[6] = '{n: 2'd2, s0: {13'd3, 13'h1FFE}, s1: {13'd3, 13'h1FFE}, s2: 26'd0,
                split: 1'b1, sign: 1'b1, exp_acc: 32'h0006_FFFC, exp_split: 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_acc", out_acc, 32'(0));
    check("rst_out_split", 32'(out_split), 32'(0));
    check("rst_mode_err", 32'(mode_err), 32'(0));

    for (int i = 0; i < 7; i++) run_group(vecs[i]);

    // random groups kept small enough that neither wrap nor clamp can occur
    for (int g = 0; g < 4; g++) begin
      n     = $urandom_range(1, 4);
      rsp   = 1'($urandom_range(0, 1));
      rsg   = 1'($urandom_range(0, 1));
      acc_m = '0;
      for (int b = 0; b < n; b++) begin
        rs    = 26'($urandom());
        acc_m = model_add(acc_m, rs, rsp, rsg);
        if (b == n - 1) exp_q.push_back({rsp, acc_m});
        drive_beat(rs, rsp, rsg, b == n - 1);
      end
      check("rand_out_valid", 32'(out_valid), 32'(1));
    end

    // backpressure: result must hold while the consumer stalls
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    exp_q.push_back({1'b0, 32'h55});
    drive_beat(26'h55, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_acc", out_acc, 32'h55);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back({1'b0, 32'd7});
    drive_beat(26'd7, 1'b0, 1'b0, 1'b1);
    check("bp_next_valid", 32'(out_valid), 32'(1));

    // mode error: second beat asks for split mode but the group stays full
    @(negedge clk);
    drive_beat(26'd4, 1'b0, 1'b0, 1'b0);
    check("me_no_err_first", 32'(mode_err), 32'(0));
    exp_q.push_back({1'b0, 32'd10});
    drive_beat(26'd6, 1'b1, 1'b0, 1'b1);
    check("me_pulse", 32'(mode_err), 32'(1));
    @(negedge clk);
    check("me_pulse_end", 32'(mode_err), 32'(0));

    // reset in the middle of a group drops the partial sum
    @(negedge clk);
    drive_beat(26'd100, 1'b0, 1'b0, 1'b0);
    drive_beat(26'd200, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_out_acc", out_acc, 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({1'b0, 32'd7});
    drive_beat(26'd7, 1'b0, 1'b0, 1'b1);
    check("post_rst_valid", 32'(out_valid), 32'(1));

    // 28-bit instance: 5 x max unsigned
`ifdef SATURATE_EN
    exp28 = 28'hFFFFFFF;
`else
    exp28 = 28'd67108859;
`endif
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      if (!in_ready28) check("acc28_in_ready", 32'(in_ready28), 32'(1));
      in_valid28 = 1'b1;
      in_sum28   = 26'h3FFFFFF;
      in_last28  = (b == 4);
      @(negedge clk);
    end
    in_valid28 = 1'b0;
    in_last28  = 1'b0;
    check("acc28_valid", 32'(out_valid28), 32'(1));
    check("acc28_value", 32'(out_acc28), 32'(exp28));
    check("acc28_split", 32'(out_split28), 32'(0));
    check("acc28_mode_err", 32'(mode_err28), 32'(0));

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
